bp_me_stream_arbiter: RTL and testbench

- N-to-1 round-robin arbiter that shares one BedRock stream (xce) output channel among num_req_p requesters.
- Grant locks from the first beat to the last beat of a multi-beat stream message, so beats from different messages never interleave.
- Beat count is derived from each message header using the same rule as the stream pump: size plus stream_mask_p.
- Sits in front of a shared memory or network stream port in bp_me.

---
 rtl/bp_me_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_bp_me_stream_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_stream_arbiter.sv
// Round-robin N-to-1 arbiter for BedRock stream channels; the grant locks for the full
// beat count of a multi-beat message so that beats from different messages never interleave.
module bp_me_stream_arbiter
  #(parameter int paddr_width_p = 40
  , parameter int bedrock_block_width_p = 512
  , parameter int payload_width_p = 8
  , parameter int data_width_p = 64
  , parameter logic [15:0] stream_mask_p = 16'h0002
  , parameter int num_req_p = 4
  , localparam int hdr_width_lp = payload_width_p + 3 + paddr_width_p + 8
  , localparam int ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
  , localparam int cnt_width_lp = $clog2(bedrock_block_width_p / data_width_p) + 1
  )
  (input  logic                                 clk_i
  , input  logic                                reset_n_i
  , input  logic [num_req_p*hdr_width_lp-1:0]   header_i
  , input  logic [num_req_p*data_width_p-1:0]   data_i
  , input  logic [num_req_p-1:0]                v_i
  , output logic [num_req_p-1:0]                ready_and_o
  , output logic [hdr_width_lp-1:0]             header_o
  , output logic [data_width_p-1:0]             data_o
  , output logic                                v_o
  , input  logic                                ready_and_i
  , output logic [num_req_p-1:0]                grant_o
  , output logic                                last_o
  );

  typedef enum logic {e_idle, e_lock} state_e;

  state_e                    state_r, state_n;
  logic [ptr_width_lp-1:0]   rr_ptr_r, rr_ptr_n;
  logic [ptr_width_lp-1:0]   grant_r, grant_n;
  logic [cnt_width_lp-1:0]   beats_left_r, beats_left_n;
  logic [ptr_width_lp-1:0]   sel_idx, cur_idx;
  logic                      sel_found, hs;
  logic [hdr_width_lp-1:0]   cur_hdr;
  logic [cnt_width_lp-1:0]   cur_beats;

  // Header layout: {payload, size[2:0], addr, subop[3:0], msg_type[3:0]}; size encodes 2^size bytes.
  function automatic logic [cnt_width_lp-1:0] beats_of(input logic [hdr_width_lp-1:0] hdr);
    logic [3:0] msg_type;
    logic [2:0] size;
    int         beats;
    msg_type = hdr[3:0];
    size     = hdr[8+paddr_width_p +: 3];
    beats    = 1;
    if (stream_mask_p[msg_type]) begin
      beats = (1 << size) / (data_width_p / 8);
      if (beats < 1) beats = 1;
    end
    return cnt_width_lp'(beats);
  endfunction

  function automatic logic [ptr_width_lp-1:0] inc_ptr(input logic [ptr_width_lp-1:0] p);
    return (int'(p) == num_req_p - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin : select
    int idx;
    idx       = 0;
    sel_idx   = rr_ptr_r;
    sel_found = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = (int'(rr_ptr_r) + k) % num_req_p;
      if (!sel_found && v_i[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ptr_width_lp'(idx);
      end
    end
  end

  always_comb begin
    state_n      = state_r;
    rr_ptr_n     = rr_ptr_r;
    grant_n      = grant_r;
    beats_left_n = beats_left_r;
    grant_o      = '0;
    v_o          = 1'b0;
    last_o       = 1'b0;

    cur_idx   = (state_r == e_lock) ? grant_r : sel_idx;
    cur_hdr   = header_i[int'(cur_idx)*hdr_width_lp +: hdr_width_lp];
    cur_beats = beats_of(cur_hdr);
    header_o  = cur_hdr;
    data_o    = data_i[int'(cur_idx)*data_width_p +: data_width_p];

    // Control outputs are forced low while reset is held, independent of the clock.
    if (reset_n_i) begin
      if (state_r == e_lock) begin
        grant_o[grant_r] = 1'b1;
        v_o              = v_i[grant_r];
        last_o           = (beats_left_r == cnt_width_lp'(1));
      end else if (sel_found) begin
        grant_o[sel_idx] = 1'b1;
        v_o              = 1'b1;
        last_o           = (cur_beats == cnt_width_lp'(1));
      end
    end

    ready_and_o = grant_o & {num_req_p{ready_and_i}};
    hs          = v_o & ready_and_i;

    if (hs) begin
      if (state_r == e_lock) begin
        beats_left_n = beats_left_r - 1'b1;
        if (beats_left_r == cnt_width_lp'(1)) begin
          state_n  = e_idle;
          rr_ptr_n = inc_ptr(grant_r);
        end
      end else if (cur_beats == cnt_width_lp'(1)) begin
        rr_ptr_n = inc_ptr(sel_idx);
      end else begin
        state_n      = e_lock;
        grant_n      = sel_idx;
        beats_left_n = cur_beats - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_idle;
      rr_ptr_r     <= '0;
      grant_r      <= '0;
      beats_left_r <= '0;
    end else begin
      state_r      <= state_n;
      rr_ptr_r     <= rr_ptr_n;
      grant_r      <= grant_n;
      beats_left_r <= beats_left_n;
    end
  end

  grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(grant_o));

  lock_header_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == e_lock && $past(state_r) == e_lock) |-> $stable(cur_hdr));

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// Bench for bp_me_stream_arbiter: table vectors, directed multi-beat sequences and
// randomized traffic against a transaction-level round-robin/lock model.
module tb_bp_me_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 8;
  localparam int PA = 40;
  localparam int HW = PW + 3 + PA + 8;
  localparam logic [15:0] MASK = 16'h0002;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N*HW-1:0]   header_i = '0;
  logic [N*DW-1:0]   data_i = '0;
  logic [N-1:0]      v_i = '0;
  logic [N-1:0]      ready_and_o;
  logic [HW-1:0]     header_o;
  logic [DW-1:0]     data_o;
  logic              v_o;
  logic              ready_and_i = 1'b0;
  logic [N-1:0]      grant_o;
  logic              last_o;

  bp_me_stream_arbiter #(
    .paddr_width_p(PA), .bedrock_block_width_p(512), .payload_width_p(PW),
    .data_width_p(DW), .stream_mask_p(MASK), .num_req_p(N)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .header_i(header_i), .data_i(data_i),
    .v_i(v_i), .ready_and_o(ready_and_o), .header_o(header_o), .data_o(data_o),
    .v_o(v_o), .ready_and_i(ready_and_i), .grant_o(grant_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [HW-1:0] hdr [N];

  // Reference model: message-level view (who owns the channel, beats still owed).
  int m_rr, m_owner, m_left;
  bit m_lock;
  int e_g;
  bit e_vo, e_last, e_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input int t, input int sz, input int tag);
    logic [HW-1:0] h;
    h = '0;
    h[3:0]       = 4'(t);
    h[8 +: PA]   = PA'(tag);
    h[8+PA +: 3] = 3'(sz);
    h[HW-1 -: PW] = PW'(tag);
    return h;
  endfunction

  function automatic int beats_of(input logic [HW-1:0] h);
    int t, sz, b;
    t  = int'(h[3:0]);
    sz = int'(h[8+PA +: 3]);
    if (!MASK[t]) return 1;
    b = (2 ** sz) / (DW / 8);
    return (b < 1) ? 1 : b;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_owner = 0; m_left = 0;
  endtask

  task automatic apply(input logic [N-1:0] v, input logic rdy);
    logic [N-1:0] eg;
    v_i = v;
    ready_and_i = rdy;
    for (int r = 0; r < N; r++) header_i[r*HW +: HW] = hdr[r];
    #2;
    if (m_lock) begin
      e_g = m_owner;
      e_vo = v[m_owner];
      e_last = (m_left == 1);
    end else begin
      e_g = -1;
      for (int k = 0; k < N; k++)
        if (e_g < 0 && v[(m_rr + k) % N]) e_g = (m_rr + k) % N;
      e_vo = (e_g >= 0);
      e_last = e_vo && (beats_of(hdr[e_g]) == 1);
    end
    e_hs = e_vo & rdy;
    eg = (e_g >= 0) ? N'(1 << e_g) : '0;
    chk("grant_o", 64'(grant_o), 64'(eg));
    chk("v_o", 64'(v_o), 64'(e_vo));
    chk("ready_and_o", 64'(ready_and_o), 64'(rdy ? eg : '0));
    if (e_vo) begin
      chk("last_o", 64'(last_o), 64'(e_last));
      chk("header_o", 64'(header_o), 64'(hdr[e_g]));
      chk("data_o", data_o, data_i[e_g*DW +: DW]);
    end
  endtask

  task automatic advance();
    int b;
    @(posedge clk);
    #1;
    if (e_hs) begin
      if (m_lock) begin
        m_left--;
        if (m_left == 0) begin
          m_lock = 0;
          m_rr = (m_owner + 1) % N;
        end
      end else begin
        b = beats_of(hdr[e_g]);
        if (b == 1) m_rr = (e_g + 1) % N;
        else begin
          m_lock = 1; m_owner = e_g; m_left = b - 1;
        end
      end
    end
  endtask

  task automatic do_reset(input bit check);
    reset_n = 1'b0;
    v_i = '1;
    ready_and_i = 1'b1;
    #2;
    if (check) begin
      chk("reset v_o", 64'(v_o), 64'd0);
      chk("reset grant_o", 64'(grant_o), 64'd0);
      chk("reset ready_and_o", 64'(ready_and_o), 64'd0);
      chk("reset last_o", 64'(last_o), 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    v_i = '0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         rdy;
    logic [N-1:0] grant;
    logic         vo;
    logic         last;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int hs_cnt, beat;
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
    vecs[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 1'b1};
    vecs[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1};
    vecs[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1};
    vecs[11] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 1'b1};

    for (int r = 0; r < N; r++) begin
      hdr[r] = mk_hdr(0, 6, 16 + r);
      data_i[r*DW +: DW] = {32'hA000_0000 + 32'(r), $urandom};
    end
    #3;
    do_reset(1);

    // Single-beat round robin and selection changes without locking.
    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].rdy);
      chk($sformatf("vec%0d grant", i), 64'(grant_o), 64'(vecs[i].grant));
      chk($sformatf("vec%0d v_o", i), 64'(v_o), 64'(vecs[i].vo));
      if (vecs[i].vo) chk($sformatf("vec%0d last", i), 64'(last_o), 64'(vecs[i].last));
      advance();
    end

    // 8-beat stream from req1 with req2 competing.
    do_reset(0);
    hdr[1] = mk_hdr(1, 6, 33);
    hdr[2] = mk_hdr(0, 6, 34);
    for (int i = 0; i < 8; i++) begin
      data_i[1*DW +: DW] = 64'hB100 + 64'(i);
      apply(4'b0110, 1'b1);
      chk("stream grant", 64'(grant_o), 64'b0010);
      chk("stream last", 64'(last_o), 64'(i == 7));
      advance();
    end
    apply(4'b0110, 1'b1);
    chk("after stream grant", 64'(grant_o), 64'b0100);
    advance();

    // 4-beat message from req3 under backpressure with req0 competing.
    hdr[3] = mk_hdr(1, 5, 35);
    hs_cnt = 0;
    beat = 0;
    for (int i = 0; i < 7; i++) begin
      logic [6:0] rseq;
      rseq = 7'b1011001;
      data_i[3*DW +: DW] = 64'hD0 + 64'(beat);
      apply(4'b1001, rseq[i]);
      chk("bp grant", 64'(grant_o), 64'b1000);
      if (v_o && ready_and_i) begin
        chk("bp data order", data_o, 64'hD0 + 64'(hs_cnt));
        hs_cnt++;
        beat++;
      end
      advance();
    end
    chk("bp handshakes", 64'(hs_cnt), 64'd4);
    apply(4'b1001, 1'b1);
    chk("after bp grant", 64'(grant_o), 64'b0001);
    advance();

    // Stream type with a sub-beat size is a single beat and never locks.
    hdr[0] = mk_hdr(1, 3, 36);
    apply(4'b0001, 1'b1);
    chk("subbeat last", 64'(last_o), 64'd1);
    advance();
    apply(4'b0100, 1'b1);
    chk("subbeat no lock", 64'(grant_o), 64'b0100);
    advance();

    // Asynchronous reset in the middle of an 8-beat message.
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      apply(4'b0010, 1'b1);
      advance();
    end
    reset_n = 1'b0;
    #1;
    chk("midreset v_o", 64'(v_o), 64'd0);
    chk("midreset grant_o", 64'(grant_o), 64'd0);
    chk("midreset ready_and_o", 64'(ready_and_o), 64'd0);
    chk("midreset last_o", 64'(last_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(4'b0011, 1'b1);
    chk("post reset grant", 64'(grant_o), 64'b0001);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        if (!(m_lock && m_owner == r) && ($urandom_range(0, 3) == 0))
          hdr[r] = mk_hdr($urandom_range(0, 2), $urandom_range(0, 6), $urandom_range(0, 255));
        data_i[r*DW +: DW] = {$urandom, $urandom};
      end
      apply(N'($urandom), ($urandom_range(0, 3) != 0));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
